bsg_manycore_stat_tag_tracker: RTL

BSG_MANYCORE_STAT_TAG_TRACKER -- requirements
Module: bsg_manycore_stat_tag_tracker

---
 rtl/bsg_manycore_stat_tag_tracker.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/bsg_manycore_stat_tag_tracker.sv
// Tracks START/END/STAT print_stat events per tag id and queues {id, duration} records in a small FIFO.
// Optional trace output is enabled by defining BSG_STAT_TAG_TRACKER_TRACE_EN.
module bsg_manycore_stat_tag_tracker #(
  parameter int data_width_p = 32,
  parameter int ctr_width_p  = 32,
  parameter int num_tags_p   = 16,
  parameter int fifo_els_p   = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          print_stat_v_i,
  input  logic [data_width_p-1:0]       print_stat_tag_i,
  input  logic [ctr_width_p-1:0]        global_ctr_i,
  output logic                          rec_v_o,
  output logic [$clog2(num_tags_p)-1:0] rec_tag_o,
  output logic [ctr_width_p-1:0]        rec_cycles_o,
  input  logic                          rec_yumi_i,
  output logic [num_tags_p-1:0]         open_mask_o,
  output logic                          err_o,
  output logic [7:0]                    drop_count_o
);

  localparam int TAG_W = $clog2(num_tags_p);
  localparam int PTR_W = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
  localparam int CNT_W = $clog2(fifo_els_p + 1);

  typedef enum logic [1:0] {
    KIND_STAT  = 2'b00,
    KIND_START = 2'b01,
    KIND_END   = 2'b10,
    KIND_NONE  = 2'b11
  } kind_e;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    next_ptr = (p == PTR_W'(fifo_els_p - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  kind_e                   w_kind;
  logic [TAG_W-1:0]        w_id;
  logic                    w_ev;
  logic                    w_unused_tag_bits;

  assign w_kind            = kind_e'(print_stat_tag_i[data_width_p-1 -: 2]);
  assign w_id              = print_stat_tag_i[TAG_W-1:0];
  assign w_ev              = print_stat_v_i & ~reset_i;
  assign w_unused_tag_bits = ^print_stat_tag_i;

  logic [num_tags_p-1:0]   r_open;
  logic                    r_err;
  logic [7:0]              r_drop;
  logic [ctr_width_p-1:0]  r_start [num_tags_p];

  logic [PTR_W-1:0]        r_wptr;
  logic [PTR_W-1:0]        r_rptr;
  logic [CNT_W-1:0]        r_count;
  logic [TAG_W-1:0]        r_fifo_tag [fifo_els_p];
  logic [ctr_width_p-1:0]  r_fifo_cyc [fifo_els_p];

  logic                    w_push;
  logic [TAG_W-1:0]        w_rec_tag;
  logic [ctr_width_p-1:0]  w_rec_cycles;
  logic                    w_start_wr;
  logic                    w_set_open;
  logic                    w_clr_open;
  logic                    w_err_set;

  // Event decode: each event yields at most one record and one open-bit change.
  always_comb begin
    w_push       = 1'b0;
    w_rec_tag    = w_id;
    w_rec_cycles = '0;
    w_start_wr   = 1'b0;
    w_set_open   = 1'b0;
    w_clr_open   = 1'b0;
    w_err_set    = 1'b0;
    if (w_ev) begin
      case (w_kind)
        KIND_STAT: w_push = 1'b1;
        KIND_START: begin
          w_start_wr = 1'b1;
          w_set_open = 1'b1;
          w_err_set  = r_open[w_id];
        end
        KIND_END: begin
          if (r_open[w_id]) begin
            w_push       = 1'b1;
            w_rec_cycles = global_ctr_i - r_start[w_id];
            w_clr_open   = 1'b1;
          end else begin
            w_err_set    = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_enq;
  logic w_drop;

  assign w_full  = (r_count == CNT_W'(fifo_els_p));
  assign w_empty = (r_count == '0);
  assign w_pop   = rec_yumi_i & ~w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_enq   = w_push & (~w_full | rec_yumi_i);
  assign w_drop  = w_push & w_full & ~rec_yumi_i;

  // Data storage: start times and FIFO payload carry no reset.
  always_ff @(posedge clk_i) begin
    if (w_start_wr) r_start[w_id] <= global_ctr_i;
    if (w_enq) begin
      r_fifo_tag[r_wptr] <= w_rec_tag;
      r_fifo_cyc[r_wptr] <= w_rec_cycles;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_open  <= '0;
      r_err   <= 1'b0;
      r_drop  <= '0;
    end else begin
      if (w_enq) r_wptr <= next_ptr(r_wptr);
      if (w_pop) r_rptr <= next_ptr(r_rptr);
      case ({w_enq, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_set_open)      r_open[w_id] <= 1'b1;
      else if (w_clr_open) r_open[w_id] <= 1'b0;
      if (w_err_set) r_err <= 1'b1;
      if (w_drop && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
    end
  end

`ifdef BSG_STAT_TAG_TRACKER_TRACE_EN
  always_ff @(posedge clk_i) begin
    if (w_enq)  $display("[STAT] tag=%0d cycles=%0d", w_rec_tag, w_rec_cycles);
    if (w_drop) $display("[STAT] DROP tag=%0d", w_rec_tag);
  end
`else
`endif

  assign rec_v_o      = ~w_empty;
  assign rec_tag_o    = r_fifo_tag[r_rptr];
  assign rec_cycles_o = r_fifo_cyc[r_rptr];
  assign open_mask_o  = r_open;
  assign err_o        = r_err;
  assign drop_count_o = r_drop;

endmodule
